// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response channel,
// redirect input and the decode-facing instruction stream.
interface fetch_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  imem_req_o;
    logic [ADDR_WIDTH-1:0] imem_addr_o;
    logic                  imem_ready_i;
    logic                  imem_rvalid_i;
    logic [DATA_WIDTH-1:0] imem_rdata_i;
    logic                  redirect_i;
    logic [ADDR_WIDTH-1:0] redirect_pc_i;
    logic                  instr_valid_o;
    logic [DATA_WIDTH-1:0] instr_o;
    logic [ADDR_WIDTH-1:0] instr_pc_o;
    logic                  instr_ready_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        input  redirect_i,
        input  redirect_pc_i,
        output instr_valid_o,
        output instr_o,
        output instr_pc_o,
        input  instr_ready_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_rvalid_i,
        output imem_rdata_i,
        output redirect_i,
        output redirect_pc_i,
        input  instr_valid_o,
        input  instr_o,
        input  instr_pc_o,
        output instr_ready_i
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end with credit-limited prefetch queue.
// Optional FETCH_BYPASS_EN: forward a response straight to decode when the queue is empty.
module fetch_unit #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    QUEUE_DEPTH = 4
) (
    input logic        clk,
    input logic        rst_n,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(QUEUE_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic [CW-1:0]         count;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         drop;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] data_q [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q   [QUEUE_DEPTH];

    logic [CW-1:0]         credits;
    logic                  req;
    logic                  accept;
    logic                  resp;
    logic                  dropping;
    logic                  head_valid;
    logic                  bypass;
    logic                  consume;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] target_pc;

    // Handshake decode: credits bound queue entries plus in-flight requests.
    always_comb begin
        credits    = DEPTH - count - outstanding;
        req        = rst_n & ~bus.redirect_i & (credits != '0);
        accept     = req & bus.imem_ready_i;
        resp       = bus.imem_rvalid_i;
        dropping   = resp & (drop != '0);
        head_valid = rst_n & (count != '0);
`ifdef FETCH_BYPASS_EN
        bypass     = rst_n & resp & ~dropping & (count == '0) & ~bus.redirect_i;
`else
        bypass     = 1'b0;
`endif
        consume    = bypass & bus.instr_ready_i;
        push       = rst_n & resp & ~dropping & ~bus.redirect_i & ~consume;
        pop        = head_valid & bus.instr_ready_i;
        target_pc  = bus.redirect_pc_i & ~ADDR_WIDTH'(3);
    end

    // Output drive: queue head first, then bypassed response, else zero.
    always_comb begin
        bus.imem_req_o    = req;
        bus.imem_addr_o   = rst_n ? fetch_pc : RESET_PC;
        bus.instr_valid_o = 1'b0;
        bus.instr_o       = '0;
        bus.instr_pc_o    = '0;
        if (head_valid) begin
            bus.instr_valid_o = 1'b1;
            bus.instr_o       = data_q[rd_ptr];
            bus.instr_pc_o    = pc_q[rd_ptr];
        end else if (bypass) begin
            bus.instr_valid_o = 1'b1;
            bus.instr_o       = bus.imem_rdata_i;
            bus.instr_pc_o    = resp_pc;
        end
    end

    // Control state: PCs, occupancy, in-flight and stale-response counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (bus.redirect_i) begin
            fetch_pc    <= target_pc;
            resp_pc     <= target_pc;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= outstanding - CW'(resp);
            drop        <= outstanding - CW'(resp);
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + STEP;
            end
            if (push | consume) begin
                resp_pc <= resp_pc + STEP;
            end
            outstanding <= outstanding + CW'(accept) - CW'(resp);
            if (dropping) begin
                drop <= drop - CW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Queue storage: each entry holds the instruction and its PC.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= bus.imem_rdata_i;
            pc_q[wr_ptr]   <= resp_pc;
        end
    end
endmodule
